// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the program-counter sequencer.
//
// Contents:
//   PC_OP_W  : width of the op field driven by the control unit.
//   pc_op_e  : operation encoding applied on a step cycle.
//              Codes 5..7 are not listed and decode as SEQ.
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        SEQ    = 3'd0,
        BR_ABS = 3'd1,
        BR_REL = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4
    } pc_op_e;

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack -- LIFO return-address stack for pc_sequencer.
//
// Parameters:
//   ADDR_W      : width of a stored return address.
//   STACK_DEPTH : number of entries (power of two, >= 2).
// Ports:
//   clk, rst : clock and asynchronous active-high reset (pointer only).
//   push     : write wdata on top of the stack (ignored when full).
//   pop      : discard the top entry (ignored when empty).
//   wdata    : return address to push.
//   rdata    : current top-of-stack entry, valid while not empty.
//   full     : stack holds STACK_DEPTH entries.
//   empty    : stack holds no entries.
module pc_ret_stack #(
    parameter int ADDR_W      = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] wdata,
    output logic [ADDR_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // ptr counts occupied entries; the extra MSB distinguishes full from empty.
    logic [PTR_W-1:0]  ptr;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    assign wr_idx  = ptr[IDX_W-1:0];
    assign top_idx = IDX_W'(ptr - 1'b1);

    assign full  = (ptr == PTR_W'(STACK_DEPTH));
    assign empty = (ptr == '0);
    assign rdata = mem[top_idx];

    // NOTE: sequential state uses non-blocking (<=) so every register in the
    // design samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; entries above the
    // pointer are never read, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with optional return stack.
//
// Build option: define PC_RET_STACK_EN to build the return-address stack and
// its flags. Without it, CALL is an unconditional absolute branch, RET is SEQ,
// stack_empty is tied 1 and stack_full/ovf/unf are tied 0.
//
// Parameters: ADDR_W (PC width), STACK_DEPTH (stack entries), RESET_ADDR.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset.
//   step        : apply one operation this cycle.
//   op          : pc_op_e code (5..7 behave as SEQ).
//   z           : branch condition for BR_ABS / BR_REL.
//   target      : absolute address (BR_ABS, CALL) or signed offset (BR_REL).
//   err_clr     : clear sticky ovf/unf (a same-cycle new error wins).
//   pc          : registered program counter.
//   stack_empty, stack_full : stack occupancy flags.
//   ovf, unf    : sticky CALL-when-full / RET-when-empty flags.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                 ADDR_W      = 32,
    parameter int                 STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [PC_OP_W-1:0] op,
    input  logic               z,
    input  logic [ADDR_W-1:0]  target,
    input  logic               err_clr,
    output logic [ADDR_W-1:0]  pc,
    output logic               stack_empty,
    output logic               stack_full,
    output logic               ovf,
    output logic               unf
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign pc     = pc_q;

`ifdef PC_RET_STACK_EN
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] rdata;
    logic              ovf_set;
    logic              unf_set;
    logic              ovf_q;
    logic              unf_q;

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );
`else
    // err_clr has nothing to clear when the stack is not built.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_next = pc_inc;
`ifdef PC_RET_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
`endif
        if (step) begin
            case (pc_op_e'(op))
                BR_ABS: if (z) pc_next = target;
                // Plain modular add: a negative offset wraps to the right place.
                BR_REL: if (z) pc_next = pc_q + target;
`ifdef PC_RET_STACK_EN
                CALL: begin
                    if (!full) begin
                        push    = 1'b1;
                        pc_next = target;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                RET: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        pc_next = rdata;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
`else
                CALL:    pc_next = target;
`endif
                default: pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_ADDR;
        end else if (step) begin
            pc_q <= pc_next;
        end
    end

`ifdef PC_RET_STACK_EN
    // Set has priority over err_clr so an error on the clearing edge is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~err_clr) | ovf_set;
            unf_q <= (unf_q & ~err_clr) | unf_set;
        end
    end

    assign stack_empty = empty;
    assign stack_full  = full;
    assign ovf         = ovf_q;
    assign unf         = unf_q;
`else
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign ovf         = 1'b0;
    assign unf         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- self-checking bench for pc_sequencer (default parameters).
// Directed scenarios followed by randomized operation streams, all compared
// against a queue-based reference model. Follows PC_RET_STACK_EN like the RTL.
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int DEPTH = 8;
`ifdef PC_RET_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               step = 1'b0;
    logic [PC_OP_W-1:0] op = '0;
    logic               z = 1'b0;
    logic [31:0]        target = '0;
    logic               err_clr = 1'b0;
    logic [31:0]        pc;
    logic               stack_empty;
    logic               stack_full;
    logic               ovf;
    logic               unf;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    bit          m_ovf;
    bit          m_unf;

    pc_sequencer #(
        .ADDR_W      (32),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .op          (op),
        .z           (z),
        .target      (target),
        .err_clr     (err_clr),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc = 32'h0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // One clock edge of the architectural behaviour.
    function automatic void model_edge(bit s, int o, bit c, logic [31:0] t, bit clr);
        logic [31:0] nxt;
        bit ov_ev;
        bit un_ev;
        nxt   = m_pc + 32'd1;
        ov_ev = 1'b0;
        un_ev = 1'b0;
        if (s) begin
            if (o == 1 && c) nxt = t;
            else if (o == 2 && c) nxt = m_pc + t;
            else if (o == 3) begin
                if (!STK_EN) nxt = t;
                else if (m_stk.size() < DEPTH) begin
                    m_stk.push_back(m_pc + 32'd1);
                    nxt = t;
                end else ov_ev = 1'b1;
            end else if (o == 4 && STK_EN) begin
                if (m_stk.size() > 0) nxt = m_stk.pop_back();
                else un_ev = 1'b1;
            end
            m_pc = nxt;
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ov_ev) m_ovf = 1'b1;
        if (un_ev) m_unf = 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        bit exp_empty;
        bit exp_full;
        exp_empty = STK_EN ? (m_stk.size() == 0) : 1'b1;
        exp_full  = STK_EN && (m_stk.size() == DEPTH);
        check({tag, ".pc"},    pc,                  m_pc);
        check({tag, ".empty"}, {31'b0, stack_empty}, {31'b0, exp_empty});
        check({tag, ".full"},  {31'b0, stack_full},  {31'b0, exp_full});
        check({tag, ".ovf"},   {31'b0, ovf},         {31'b0, m_ovf});
        check({tag, ".unf"},   {31'b0, unf},         {31'b0, m_unf});
    endtask

    // Drive one cycle on the falling edge, update the model on the rising edge.
    task automatic cycle(input string tag, input bit s, input int o, input bit c,
                         input logic [31:0] t, input bit clr);
        @(negedge clk);
        step    = s;
        op      = PC_OP_W'(o);
        z       = c;
        target  = t;
        err_clr = clr;
        @(posedge clk);
        model_edge(s, o, c, t, clr);
        #1;
        check_outputs(tag);
    endtask

    // Assert reset between edges; outputs must respond before any clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        step    = 1'b0;
        err_clr = 1'b0;
        #1 rst  = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_outputs("reset");

        // Reset mid-run, then sequential stepping and holding.
        cycle("seq_pre", 1, 0, 0, 32'h0, 0);
        cycle("seq_pre", 1, 0, 0, 32'h0, 0);
        pulse_reset("mid_reset");
        check("after_reset_pc", pc, 32'h0);
        cycle("seq1", 1, 0, 0, 32'h0, 0);
        cycle("seq2", 1, 7, 0, 32'h0, 0);
        cycle("seq3", 1, 5, 0, 32'h0, 0);
        check("seq_pc3", pc, 32'h3);
        cycle("hold1", 0, 1, 1, 32'h99, 0);
        cycle("hold2", 0, 3, 1, 32'h99, 0);
        check("hold_pc3", pc, 32'h3);

        // Branches from 0x10.
        cycle("goto10", 1, 1, 1, 32'h10, 0);
        cycle("br_abs_nt", 1, 1, 0, 32'h40, 0);
        check("br_abs_nt_pc", pc, 32'h11);
        cycle("goto10", 1, 1, 1, 32'h10, 0);
        cycle("br_abs_t", 1, 1, 1, 32'h40, 0);
        check("br_abs_t_pc", pc, 32'h40);
        cycle("br_rel_neg", 1, 2, 1, 32'hFFFF_FFFC, 0);
        check("br_rel_neg_pc", pc, 32'h3C);
        cycle("br_rel_nt", 1, 2, 0, 32'h100, 0);

        // Wrap-around.
        cycle("gotomax", 1, 1, 1, 32'hFFFF_FFFF, 0);
        cycle("wrap", 1, 0, 0, 32'h0, 0);
        check("wrap_pc", pc, 32'h0);

`ifdef PC_RET_STACK_EN
        // Nested call / return.
        cycle("goto5", 1, 1, 1, 32'h5, 0);
        cycle("call1", 1, 3, 0, 32'h100, 0);
        cycle("call2", 1, 3, 0, 32'h200, 0);
        cycle("ret1", 1, 4, 0, 32'h0, 0);
        check("ret1_pc", pc, 32'h101);
        cycle("ret2", 1, 4, 0, 32'h0, 0);
        check("ret2_pc", pc, 32'h6);
        check("ret2_empty", {31'b0, stack_empty}, 32'h1);

        // Overflow, underflow, clear, set-wins.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 3, 0, 32'h300, 0);
        check("fill_full", {31'b0, stack_full}, 32'h1);
        cycle("call_ovf", 1, 3, 0, 32'h500, 0);
        check("ovf_pc", pc, 32'h301);
        check("ovf_flag", {31'b0, ovf}, 32'h1);
        for (int i = 0; i < DEPTH; i++) cycle("drain", 1, 4, 0, 32'h0, 0);
        check("drain_empty", {31'b0, stack_empty}, 32'h1);
        cycle("ret_unf", 1, 4, 0, 32'h0, 0);
        check("unf_flag", {31'b0, unf}, 32'h1);
        cycle("clr_set_wins", 1, 4, 0, 32'h0, 1);
        check("set_wins_unf", {31'b0, unf}, 32'h1);
        check("set_wins_ovf", {31'b0, ovf}, 32'h0);
        cycle("err_clr", 0, 0, 0, 32'h0, 1);
        check("clr_ovf", {31'b0, ovf}, 32'h0);
        check("clr_unf", {31'b0, unf}, 32'h0);
`else
        // Stack not built: CALL jumps, RET steps, flags stay idle.
        cycle("call_nostk", 1, 3, 0, 32'h80, 0);
        check("call_nostk_pc", pc, 32'h80);
        cycle("ret_nostk", 1, 4, 0, 32'h0, 0);
        check("ret_nostk_pc", pc, 32'h81);
        check("nostk_empty", {31'b0, stack_empty}, 32'h1);
        check("nostk_ovf", {31'b0, ovf}, 32'h0);
        check("nostk_unf", {31'b0, unf}, 32'h0);
`endif

        // Randomized streams; call/ret weighted so the stack hits both ends.
        for (int n = 0; n < 600; n++) begin
            int          o;
            logic [31:0] t;
            bit          s;
            if ($urandom_range(0, 99) == 0) pulse_reset("rand_reset");
            o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                            : int'($urandom_range(3, 4));
            if (n % 200 < 100 && $urandom_range(0, 1) == 1) o = 3;
            t = ($urandom_range(0, 1) == 1) ? $urandom
                                            : 32'($signed($urandom_range(0, 64)) - 32);
            s = ($urandom_range(0, 9) != 0);
            cycle("rand", s, o, 1'($urandom_range(0, 1)), t,
                  ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the basic microprocessor datapath. It advances the instruction address on each `step` strobe from the control unit. Supported moves are sequential advance, conditional absolute branch, conditional PC-relative branch, subroutine call and return. A hardware return-address stack buffers return addresses. Its output drives the instruction-memory address.

## Interface
Parameters:
- `ADDR_W`, 32: PC / address width in bits.
- `STACK_DEPTH`, 8: return-stack entries; power of two, at least 2.
- `RESET_ADDR`, 0: PC value held in reset.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `step` in 1: advance strobe. Exactly one PC update per cycle in which it is high.
- `op` in 3: operation applied on a `step` cycle: 0 SEQ, 1 BR_ABS, 2 BR_REL, 3 CALL, 4 RET. Codes 5–7 are treated as SEQ.
- `z` in 1: branch condition, sampled only for BR_ABS and BR_REL.
- `target` in ADDR_W:
  - Absolute address for BR_ABS and CALL.
  - Signed two's-complement offset for BR_REL.
- `err_clr` in 1: synchronous clear of sticky error flags.
- `pc` out ADDR_W: current PC (registered).
- `stack_empty` out 1: return stack holds 0 entries.
- `stack_full` out 1: return stack holds STACK_DEPTH entries.
- `ovf` out 1: sticky flag; a CALL was issued while the stack was full.
- `unf` out 1: sticky flag; a RET was issued while the stack was empty.

## Operation
- `step`=0: PC and stack hold. `op`, `z` and `target` are ignored.
- `step`=1, next PC by `op`:
  - SEQ: PC+1.
  - BR_ABS: `target` if z=1, else PC+1.
  - BR_REL: PC+`target` if z=1, else PC+1.
  - CALL, stack not full: push PC+1, then PC←`target`.
  - CALL, stack full: no push, PC←PC+1, set `ovf`.
  - RET, stack not empty: pop, PC←popped value.
  - RET, stack empty: PC←PC+1, set `unf`.
- Arithmetic rules:
  - All PC arithmetic is modulo 2^ADDR_W; all-ones+1 wraps to 0.
  - BR_REL adds the full ADDR_W offset, so negative offsets wrap correctly.
- Stack is a LIFO with a pointer of width clog2(STACK_DEPTH)+1.
- Flag behaviour:
  - `stack_full` and `stack_empty` are derived combinationally from the pointer.
  - `ovf` and `unf` stay set until `err_clr` or `rst`.
  - `err_clr` together with a new error event in the same cycle: the flag ends set, because set wins.
- Reset values:
  - `pc`=RESET_ADDR, stack pointer 0, `stack_empty`=1, `stack_full`=0, `ovf`=0, `unf`=0.
  - Stack contents are not reset.
- Reset mid-operation: assertion forces reset values immediately, without waiting for a clock edge. The first update after deassertion occurs at the first rising edge where `rst`=0 and `step`=1.

## Timing
- Latency is one cycle: the `pc` change is visible after the rising edge that samples `step`=1.
- Back-to-back `step` cycles are allowed; each applies one operation.
- CALL and RET stack writes, reads and pointer updates happen on the same edge as the PC update.
- Flag timing:
  - `stack_full` and `stack_empty` are valid the cycle after that edge.
  - `ovf` and `unf` assert on the offending edge.
- There is no combinational path from inputs to `pc`.

## Configuration
- `PC_RET_STACK_EN` defined: return stack and its flags are built as described.
- Not defined:
  - No stack storage is built.
  - CALL behaves as an unconditional BR_ABS.
  - RET behaves as SEQ.
  - `stack_empty` is tied to 1; `stack_full`, `ovf` and `unf` are tied to 0.
  - Ports are unchanged.

## Structure
- Shared package `pc_pkg`:
  - Opcode enum `pc_op_e` (SEQ, BR_ABS, BR_REL, CALL, RET).
  - Opcode width constant `PC_OP_W`=3.
- Sub-module `pc_ret_stack`:
  - Parametrised by `ADDR_W` and `STACK_DEPTH`.
  - Ports: push, pop, wdata, rdata, full, empty, with async reset of the pointer.
  - Instantiated only under `PC_RET_STACK_EN`.
- The top level holds the PC register, next-PC mux and sticky error flags.

## Test plan
- Reset and SEQ: assert `rst` mid-run, then release; run 3 SEQ steps → `pc`=0,1,2,3. Hold `step` low for 2 cycles → `pc` stays 3.
- Branches at PC=0x10:
  - BR_ABS with target=0x40, z=0 → `pc`=0x11.
  - BR_ABS with target=0x40, z=1 → `pc`=0x40.
  - BR_REL with target=0xFFFFFFFC (−4), z=1 → `pc`=0x3C.
- Wrap-around: PC=0xFFFFFFFF, SEQ → `pc`=0x00000000.
- Nested call/return with STACK_DEPTH=8:
  - At PC=5, CALL 0x100; at 0x100, CALL 0x200.
  - RET → `pc`=0x101; RET → `pc`=6; `stack_empty`=1.
- Overflow and underflow:
  - 8 CALLs → `stack_full`=1. A 9th CALL at PC=0x300 → `pc`=0x301 and `ovf`=1.
  - 8 RETs empty the stack. A 9th RET → PC+1 and `unf`=1.
  - `err_clr` → both flags 0.
- Macro off: CALL 0x80 → `pc`=0x80; RET → PC+1; `stack_empty`=1 and `ovf`=`unf`=0 throughout.
